// File: rtl/sa_ui_pkg.sv
// Shared front-panel / systolic-array UI definitions: state encoding and
// default operand geometry reused by the loader, display driver and array top.
package sa_ui_pkg;

  // Sequencer states; the encoding is shown directly on the LEDs.
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    RUN    = 2'd2,
    SHOW   = 2'd3
  } ui_state_e;

  localparam int DEF_N  = 2;
  localparam int DEF_DW = 8;

endpackage

// File: rtl/switch_matrix_loader.sv
// Front-panel sequencer: captures switch values into operand matrices A and B
// one element per button press, fires a single-cycle start into the systolic
// array, waits for its done strobe and holds the result display until the
// next press.
module switch_matrix_loader
  import sa_ui_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW,
  localparam int IW = $clog2(N*N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_next,
  input  logic            btn_clr,
  input  logic [DW-1:0]   sw_data,
  input  logic            array_done,
  output logic [N*N*DW-1:0] mat_a,
  output logic [N*N*DW-1:0] mat_b,
  output logic            array_start,
  output logic [IW-1:0]   idx,
  output logic [1:0]      state_code
);

  localparam int         NEL  = N*N;
  localparam logic [IW-1:0] LAST = IW'(NEL-1);

  ui_state_e         state_q;
  logic [IW-1:0]     idx_q;
  logic              start_q;
  logic [DW-1:0]     a_q [NEL];
  logic [DW-1:0]     b_q [NEL];

  // Final element of the current operand: wrap explicitly rather than
  // relying on counter overflow, since N*N need not be a power of two.
  logic last_el;
  assign last_el = (idx_q == LAST);

  // Sequencer, element index, operand storage and start strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      start_q <= 1'b0;
      for (int k = 0; k < NEL; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      // start is a pulse; only the final-B-capture branch re-raises it
      start_q <= 1'b0;
      if (btn_clr) begin
        // clear overrides any simultaneous press, so no capture happens
        state_q <= LOAD_A;
        idx_q   <= '0;
        for (int k = 0; k < NEL; k++) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
        end
      end else begin
        case (state_q)
          LOAD_A: begin
            if (btn_next) begin
              a_q[idx_q] <= sw_data;
              if (last_el) begin
                idx_q   <= '0;
                state_q <= LOAD_B;
              end else begin
                idx_q <= idx_q + IW'(1);
              end
            end
          end
          LOAD_B: begin
            if (btn_next) begin
              b_q[idx_q] <= sw_data;
              if (last_el) begin
                idx_q   <= '0;
                state_q <= RUN;
                start_q <= 1'b1;
              end else begin
                idx_q <= idx_q + IW'(1);
              end
            end
          end
          RUN: begin
            // presses are ignored while the array computes; a done that
            // coincides with the start cycle is still accepted here
            if (array_done) state_q <= SHOW;
          end
          SHOW: begin
            // operands are kept and get overwritten element by element
            if (btn_next) begin
              state_q <= LOAD_A;
              idx_q   <= '0;
            end
          end
          default: state_q <= LOAD_A;
        endcase
      end
    end
  end

  // Flatten storage onto the output buses: element k = row*N+col.
  genvar gk;
  generate
    for (gk = 0; gk < NEL; gk++) begin : g_flat
      assign mat_a[gk*DW +: DW] = a_q[gk];
      assign mat_b[gk*DW +: DW] = b_q[gk];
    end
  endgenerate

  assign array_start = start_q;
  assign idx         = idx_q;
  assign state_code  = state_q;

endmodule

// File: tb/tb_switch_matrix_loader.sv
// Bench for switch_matrix_loader (N=2, DW=8): directed vector table, a few
// hand-written multi-cycle corner cases, then randomized presses checked
// against a press-counting reference model.
module tb_switch_matrix_loader;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              btn_next, btn_clr, array_done;
  logic [DW-1:0]     sw_data;
  logic [N*N*DW-1:0] mat_a, mat_b;
  logic              array_start;
  logic [IW-1:0]     idx;
  logic [1:0]        state_code;

  int n_chk = 0;
  int n_err = 0;

  switch_matrix_loader #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_clr(btn_clr),
    .sw_data(sw_data), .array_done(array_done), .mat_a(mat_a), .mat_b(mat_b),
    .array_start(array_start), .idx(idx), .state_code(state_code)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Loading is a count of accepted presses 0..7: the first four fill A,
  // the next four fill B. Phase 0 = loading, 1 = running, 2 = showing.
  int        m_cnt, m_phase;
  bit        m_start;
  bit [7:0]  m_a [4];
  bit [7:0]  m_b [4];

  function automatic void model_reset();
    m_cnt = 0; m_phase = 0; m_start = 0;
    for (int k = 0; k < 4; k++) begin m_a[k] = 0; m_b[k] = 0; end
  endfunction

  function automatic void model_step(bit nx, bit cl, bit dn, bit [7:0] sw);
    m_start = 0;
    if (cl) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (nx) begin
        if (m_cnt < 4) m_a[m_cnt] = sw; else m_b[m_cnt-4] = sw;
        m_cnt++;
        if (m_cnt == 8) begin m_cnt = 0; m_phase = 1; m_start = 1; end
      end
    end else if (m_phase == 1) begin
      if (dn) m_phase = 2;
    end else if (nx) begin
      m_phase = 0; m_cnt = 0;
    end
  endfunction

  function automatic logic [1:0] model_state();
    if (m_phase == 0) return (m_cnt < 4) ? 2'd0 : 2'd1;
    return (m_phase == 1) ? 2'd2 : 2'd3;
  endfunction

  function automatic logic [31:0] pack4(bit [7:0] e [4]);
    return {e[3], e[2], e[1], e[0]};
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".state"}, 32'(state_code), 32'(model_state()));
    chk({tag, ".idx"},   32'(idx),        32'(m_cnt % 4));
    chk({tag, ".start"}, 32'(array_start), 32'(m_start));
    chk({tag, ".mat_a"}, mat_a, pack4(m_a));
    chk({tag, ".mat_b"}, mat_b, pack4(m_b));
  endtask

  // Drive one cycle of inputs at a negedge, let the posedge sample them,
  // return at the next negedge with inputs idle and the model advanced.
  task automatic apply(bit nx, bit cl, bit dn, bit [7:0] sw);
    btn_next = nx; btn_clr = cl; array_done = dn; sw_data = sw;
    @(negedge clk);
    btn_next = 0; btn_clr = 0; array_done = 0;
    model_step(nx, cl, dn, sw);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit        nx, cl, dn;
    bit [7:0]  sw;
    bit [1:0]  st;
    bit [1:0]  ix;
    bit        start;
    bit [31:0] ea, eb;
  } vec_t;

  vec_t tv [$];

  function automatic void add(bit nx, bit cl, bit dn, bit [7:0] sw, bit [1:0] st,
                              bit [1:0] ix, bit start, bit [31:0] ea, bit [31:0] eb);
    vec_t v;
    v.nx = nx; v.cl = cl; v.dn = dn; v.sw = sw; v.st = st; v.ix = ix;
    v.start = start; v.ea = ea; v.eb = eb;
    tv.push_back(v);
  endfunction

  initial begin
    rst_n = 0; btn_next = 0; btn_clr = 0; array_done = 0; sw_data = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("reset.state", 32'(state_code), 0);
    chk("reset.idx",   32'(idx), 0);
    chk("reset.start", 32'(array_start), 0);
    chk("reset.mat_a", mat_a, 0);
    chk("reset.mat_b", mat_b, 0);
    rst_n = 1;
    @(negedge clk);

    //  nx cl dn sw     st ix s  mat_a         mat_b
    add(1, 0, 0, 8'h01, 0, 1, 0, 32'h00000001, 32'h0);
    add(1, 0, 0, 8'h02, 0, 2, 0, 32'h00000201, 32'h0);
    add(1, 0, 0, 8'h03, 0, 3, 0, 32'h00030201, 32'h0);
    add(1, 0, 0, 8'h04, 1, 0, 0, 32'h04030201, 32'h0);
    add(1, 0, 0, 8'h05, 1, 1, 0, 32'h04030201, 32'h00000005);
    add(1, 0, 0, 8'h06, 1, 2, 0, 32'h04030201, 32'h00000605);
    add(1, 0, 0, 8'h07, 1, 3, 0, 32'h04030201, 32'h00070605);
    add(1, 0, 0, 8'h08, 2, 0, 1, 32'h04030201, 32'h08070605);
    add(0, 0, 0, 8'h00, 2, 0, 0, 32'h04030201, 32'h08070605);
    add(1, 0, 0, 8'hAA, 2, 0, 0, 32'h04030201, 32'h08070605); // press ignored in RUN
    add(0, 0, 1, 8'h00, 3, 0, 0, 32'h04030201, 32'h08070605);
    add(1, 0, 0, 8'h55, 0, 0, 0, 32'h04030201, 32'h08070605); // SHOW->LOAD_A, no capture
    add(0, 0, 1, 8'h00, 0, 0, 0, 32'h04030201, 32'h08070605); // done ignored in LOAD_A
    add(1, 0, 0, 8'h11, 0, 1, 0, 32'h04030211, 32'h08070605);
    add(1, 0, 0, 8'h22, 0, 2, 0, 32'h04032211, 32'h08070605);
    add(1, 0, 0, 8'h33, 0, 3, 0, 32'h04332211, 32'h08070605);
    add(1, 0, 0, 8'h44, 1, 0, 0, 32'h44332211, 32'h08070605);
    add(1, 0, 0, 8'h99, 1, 1, 0, 32'h44332211, 32'h08070699);
    add(1, 0, 0, 8'h98, 1, 2, 0, 32'h44332211, 32'h08079899);
    add(1, 1, 0, 8'h77, 0, 0, 0, 32'h0,        32'h0);        // clr wins over next
    add(1, 0, 0, 8'h10, 0, 1, 0, 32'h00000010, 32'h0);        // 8 back-to-back
    add(1, 0, 0, 8'h11, 0, 2, 0, 32'h00001110, 32'h0);
    add(1, 0, 0, 8'h12, 0, 3, 0, 32'h00121110, 32'h0);
    add(1, 0, 0, 8'h13, 1, 0, 0, 32'h13121110, 32'h0);
    add(1, 0, 0, 8'h14, 1, 1, 0, 32'h13121110, 32'h00000014);
    add(1, 0, 0, 8'h15, 1, 2, 0, 32'h13121110, 32'h00001514);
    add(1, 0, 0, 8'h16, 1, 3, 0, 32'h13121110, 32'h00161514);
    add(1, 0, 0, 8'h17, 2, 0, 1, 32'h13121110, 32'h17161514);
    add(0, 0, 0, 8'h00, 2, 0, 0, 32'h13121110, 32'h17161514); // single start
    add(0, 0, 0, 8'h00, 2, 0, 0, 32'h13121110, 32'h17161514);
    add(0, 0, 1, 8'h00, 3, 0, 0, 32'h13121110, 32'h17161514);
    add(1, 0, 0, 8'h00, 0, 0, 0, 32'h13121110, 32'h17161514);

    for (int i = 0; i < tv.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      apply(tv[i].nx, tv[i].cl, tv[i].dn, tv[i].sw);
      chk({t, ".state"}, 32'(state_code), 32'(tv[i].st));
      chk({t, ".idx"},   32'(idx), 32'(tv[i].ix));
      chk({t, ".start"}, 32'(array_start), 32'(tv[i].start));
      chk({t, ".mat_a"}, mat_a, tv[i].ea);
      chk({t, ".mat_b"}, mat_b, tv[i].eb);
    end

    // array_done in the same cycle array_start is high is accepted
    for (int k = 0; k < 8; k++) apply(1, 0, 0, 8'(8'hC0 + k));
    chk("done_w_start.start", 32'(array_start), 1);
    apply(0, 0, 1, 8'h00);
    chk("done_w_start.state", 32'(state_code), 3);
    chk_model("done_w_start");
    apply(1, 0, 0, 8'h00);
    chk_model("show_exit");

    // reset asserted while array_start is high: outputs drop at once
    for (int k = 0; k < 8; k++) apply(1, 0, 0, 8'(8'h30 + k));
    chk("pre_rst.start", 32'(array_start), 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst.start", 32'(array_start), 0);
    chk("async_rst.state", 32'(state_code), 0);
    chk("async_rst.idx",   32'(idx), 0);
    chk("async_rst.mat_a", mat_a, 0);
    chk("async_rst.mat_b", mat_b, 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      apply(0, 0, 0, 8'h00);
      chk_model($sformatf("post_rst%0d", k));
    end

    // randomized presses against the reference model
    for (int i = 0; i < 400; i++) begin
      bit nx, cl, dn;
      nx = ($urandom_range(0, 99) < 45);
      cl = ($urandom_range(0, 99) < 3);
      dn = ($urandom_range(0, 99) < 20);
      apply(nx, cl, dn, 8'($urandom));
      chk_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
